vga_timing_lookahead: RTL and testbench

Parametrised VGA timing generator. Produces display-aligned pixel coordinates and syncs, plus a second coordinate pair running LOOKAHEAD pixels ahead with its own enable and strobes. Drawing pipelines use the ahead pair to start each pixel early. Both pairs come from independent registered counters, with no adder-based wrap logic. Sits between the pixel clock domain and drawing_logic.

---
 rtl/vga_timing_lookahead.sv | 130 +++++++++++++
 tb/tb_vga_timing_lookahead.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_lookahead.sv
// VGA raster timing: display-aligned x/y + syncs, plus an ahead x/y pair leading by LOOKAHEAD pixels.
// Latency: syncs/enables registered from next-state counters, so aligned with sx/sy; strobes combinational.
// Backpressure: none; pix_ce gates every advance and all registered outputs hold while it is low.
//
// Ports:
//   vga_pix_clk, rst_n (async active-low), pix_ce (pixel advance enable)
//   sx, sy, display_enabled, H_SYNC, V_SYNC            -- display-aligned pair
//   sx_aot, sy_aot, display_enabled_aot                -- ahead pair (LOOKAHEAD pixels early)
//   line_stb_aot, frame_stb_aot                        -- 1-cycle pulses at ahead x==0 / (0,0), gated by pix_ce
//   frame_cnt (16b)                                    -- only when FRAME_COUNTER_EN is defined
//
// Optional build macro: FRAME_COUNTER_EN adds a 16-bit frame counter output.

module vga_timing_lookahead #(
    parameter int H_VISIBLE_AREA = 640,
    parameter int H_FRONT_PORCH  = 16,
    parameter int H_SYNC_PULSE   = 96,
    parameter int H_BACK_PORCH   = 48,
    parameter int V_VISIBLE_AREA = 480,
    parameter int V_FRONT_PORCH  = 10,
    parameter int V_SYNC_PULSE   = 2,
    parameter int V_BACK_PORCH   = 33,
    parameter int LOOKAHEAD      = 3,
    parameter bit H_SYNC_POL     = 1'b0,
    parameter bit V_SYNC_POL     = 1'b0,
    localparam int H_WHOLE_LINE  = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH,
    localparam int V_WHOLE_LINE  = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH,
    localparam int HW            = $clog2(H_WHOLE_LINE),
    localparam int VW            = $clog2(V_WHOLE_LINE)
) (
    input  logic          vga_pix_clk,
    input  logic          rst_n,
    input  logic          pix_ce,
    output logic [HW-1:0] sx,
    output logic [VW-1:0] sy,
    output logic          display_enabled,
    output logic          H_SYNC,
    output logic          V_SYNC,
    output logic [HW-1:0] sx_aot,
    output logic [VW-1:0] sy_aot,
    output logic          display_enabled_aot,
    output logic          line_stb_aot,
    output logic          frame_stb_aot
`ifdef FRAME_COUNTER_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    localparam int HS_START = H_VISIBLE_AREA + H_FRONT_PORCH;
    localparam int HS_END   = HS_START + H_SYNC_PULSE;
    localparam int VS_START = V_VISIBLE_AREA + V_FRONT_PORCH;
    localparam int VS_END   = VS_START + V_SYNC_PULSE;

    localparam logic [HW-1:0] H_LAST = HW'(H_WHOLE_LINE - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_WHOLE_LINE - 1);
    localparam logic [HW-1:0] LA_X   = HW'(LOOKAHEAD);

    // The ahead pair is seeded at (LOOKAHEAD, 0) and counts in lock-step with
    // the display pair, so it only stays LOOKAHEAD ahead if it never needs to
    // start on a later line.
    if (LOOKAHEAD < 0 || LOOKAHEAD >= H_WHOLE_LINE) begin : g_lookahead_range
        $error("vga_timing_lookahead: LOOKAHEAD must be in 0..H_WHOLE_LINE-1");
    end

    function automatic logic in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v < hi);
    endfunction

    logic [HW-1:0] sx_nxt, sx_aot_nxt;
    logic [VW-1:0] sy_nxt, sy_aot_nxt;

    // Plain wrap-around counters for both pairs; no offset arithmetic between them.
    always_comb begin
        sx_nxt     = sx + HW'(1);
        sy_nxt     = sy;
        sx_aot_nxt = sx_aot + HW'(1);
        sy_aot_nxt = sy_aot;
        if (sx == H_LAST) begin
            sx_nxt = '0;
            sy_nxt = (sy == V_LAST) ? '0 : sy + VW'(1);
        end
        if (sx_aot == H_LAST) begin
            sx_aot_nxt = '0;
            sy_aot_nxt = (sy_aot == V_LAST) ? '0 : sy_aot + VW'(1);
        end
    end

    // Enables and syncs are decoded from the next-state counters so that,
    // once registered, they line up with the sx/sy they describe.
    always_ff @(posedge vga_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            sx                  <= '0;
            sy                  <= '0;
            display_enabled     <= 1'b1;
            H_SYNC              <= ~H_SYNC_POL;
            V_SYNC              <= ~V_SYNC_POL;
            sx_aot              <= LA_X;
            sy_aot              <= '0;
            display_enabled_aot <= (LOOKAHEAD < H_VISIBLE_AREA);
        end else if (pix_ce) begin
            sx                  <= sx_nxt;
            sy                  <= sy_nxt;
            display_enabled     <= in_range(int'(sx_nxt), 0, H_VISIBLE_AREA) &&
                                   in_range(int'(sy_nxt), 0, V_VISIBLE_AREA);
            H_SYNC              <= in_range(int'(sx_nxt), HS_START, HS_END) ? H_SYNC_POL : ~H_SYNC_POL;
            V_SYNC              <= in_range(int'(sy_nxt), VS_START, VS_END) ? V_SYNC_POL : ~V_SYNC_POL;
            sx_aot              <= sx_aot_nxt;
            sy_aot              <= sy_aot_nxt;
            display_enabled_aot <= in_range(int'(sx_aot_nxt), 0, H_VISIBLE_AREA) &&
                                   in_range(int'(sy_aot_nxt), 0, V_VISIBLE_AREA);
        end
    end

    // Strobes mark the cycle that will advance away from ahead x==0, so they are
    // qualified by pix_ce; rst_n keeps them quiet while the counters sit at reset.
    assign line_stb_aot  = rst_n & pix_ce & (sx_aot == '0);
    assign frame_stb_aot = line_stb_aot & (sy_aot == '0);

`ifdef FRAME_COUNTER_EN
    always_ff @(posedge vga_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_stb_aot) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_lookahead.sv
// Bench for vga_timing_lookahead: four instances (default timing, LOOKAHEAD=799,
// small active-high timing with LOOKAHEAD=5, small timing with LOOKAHEAD=0).
// Expected responses are queued per cycle and checked by an independent monitor.

module tb_vga_timing_lookahead;

    localparam int N = 4;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic pix_ce = 1'b1;
    always #5 clk = ~clk;

    int cyc_now = 0;
    always @(posedge clk) cyc_now <= cyc_now + 1;

    logic [9:0] a_sx, a_sy, a_sxa, a_sya;
    logic [9:0] b_sx, b_sy, b_sxa, b_sya;
    logic [3:0] c_sx, c_sxa, d_sx, d_sxa;
    logic [2:0] c_sy, c_sya, d_sy, d_sya;
    logic a_de, a_hs, a_vs, a_dea, a_ls, a_fs;
    logic b_de, b_hs, b_vs, b_dea, b_ls, b_fs;
    logic c_de, c_hs, c_vs, c_dea, c_ls, c_fs;
    logic d_de, d_hs, d_vs, d_dea, d_ls, d_fs;
`ifdef FRAME_COUNTER_EN
    logic [15:0] a_fc, b_fc, c_fc, d_fc;
`endif

    vga_timing_lookahead u_a (
        .vga_pix_clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
        .sx(a_sx), .sy(a_sy), .display_enabled(a_de), .H_SYNC(a_hs), .V_SYNC(a_vs),
        .sx_aot(a_sxa), .sy_aot(a_sya), .display_enabled_aot(a_dea),
        .line_stb_aot(a_ls), .frame_stb_aot(a_fs)
`ifdef FRAME_COUNTER_EN
        , .frame_cnt(a_fc)
`endif
    );

    vga_timing_lookahead #(.LOOKAHEAD(799)) u_b (
        .vga_pix_clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
        .sx(b_sx), .sy(b_sy), .display_enabled(b_de), .H_SYNC(b_hs), .V_SYNC(b_vs),
        .sx_aot(b_sxa), .sy_aot(b_sya), .display_enabled_aot(b_dea),
        .line_stb_aot(b_ls), .frame_stb_aot(b_fs)
`ifdef FRAME_COUNTER_EN
        , .frame_cnt(b_fc)
`endif
    );

    vga_timing_lookahead #(
        .H_VISIBLE_AREA(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(3),
        .V_VISIBLE_AREA(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
        .LOOKAHEAD(5), .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
    ) u_c (
        .vga_pix_clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
        .sx(c_sx), .sy(c_sy), .display_enabled(c_de), .H_SYNC(c_hs), .V_SYNC(c_vs),
        .sx_aot(c_sxa), .sy_aot(c_sya), .display_enabled_aot(c_dea),
        .line_stb_aot(c_ls), .frame_stb_aot(c_fs)
`ifdef FRAME_COUNTER_EN
        , .frame_cnt(c_fc)
`endif
    );

    vga_timing_lookahead #(
        .H_VISIBLE_AREA(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(3),
        .V_VISIBLE_AREA(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
        .LOOKAHEAD(0)
    ) u_d (
        .vga_pix_clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
        .sx(d_sx), .sy(d_sy), .display_enabled(d_de), .H_SYNC(d_hs), .V_SYNC(d_vs),
        .sx_aot(d_sxa), .sy_aot(d_sya), .display_enabled_aot(d_dea),
        .line_stb_aot(d_ls), .frame_stb_aot(d_fs)
`ifdef FRAME_COUNTER_EN
        , .frame_cnt(d_fc)
`endif
    );

    // Per-instance timing, used by the linear-position reference model.
    int p_hv [N] = '{640, 640, 8, 8};
    int p_hf [N] = '{16, 16, 2, 2};
    int p_hs [N] = '{96, 96, 3, 3};
    int p_hb [N] = '{48, 48, 3, 3};
    int p_vv [N] = '{480, 480, 4, 4};
    int p_vf [N] = '{10, 10, 1, 1};
    int p_vs [N] = '{2, 2, 2, 2};
    int p_vb [N] = '{33, 33, 1, 1};
    int p_la [N] = '{3, 799, 5, 0};
    int p_hp [N] = '{0, 0, 1, 0};
    int p_vp [N] = '{0, 0, 1, 0};

    typedef struct packed {
        int cyc; int kind; int id;
        int sx; int sy; int sxa; int sya; int fc;
        bit de; bit hs; bit vs; bit dea; bit ls; bit fs;
    } exp_t;

    exp_t   q[$];
    longint n_adv = 0;
    int     vectors = 0;
    int     errors  = 0;

    function automatic string kind_name(input int k);
        case (k)
            0:       return "model";
            1:       return "reset_default";
            2:       return "reset_la799";
            3:       return "reset_small_pol1";
            4:       return "reset_la0";
            5:       return "hsync_edge";
            6:       return "ahead_line_wrap_797";
            7:       return "la799_wrap";
            8:       return "small_vsync";
            9:       return "small_frame_stb";
            10:      return "async_mid_reset";
            default: return "unknown";
        endcase
    endfunction

    // Reference derived from the linear pixel index n since reset.
    function automatic exp_t model(input int id, input longint n, input bit rn, input bit ce);
        exp_t   e;
        longint hwl, vwl, t, p, a, k0;
        bit     hp, vp;
        hwl = p_hv[id] + p_hf[id] + p_hs[id] + p_hb[id];
        vwl = p_vv[id] + p_vf[id] + p_vs[id] + p_vb[id];
        t   = hwl * vwl;
        p   = n % t;
        a   = (p + p_la[id]) % t;
        hp  = (p_hp[id] != 0);
        vp  = (p_vp[id] != 0);
        e       = '0;
        e.cyc   = cyc_now;
        e.id    = id;
        e.sx    = int'(p % hwl);
        e.sy    = int'(p / hwl);
        e.sxa   = int'(a % hwl);
        e.sya   = int'(a / hwl);
        e.de    = (e.sx < p_hv[id]) && (e.sy < p_vv[id]);
        e.dea   = (e.sxa < p_hv[id]) && (e.sya < p_vv[id]);
        e.hs    = (e.sx >= p_hv[id] + p_hf[id] && e.sx < p_hv[id] + p_hf[id] + p_hs[id]) ? hp : !hp;
        e.vs    = (e.sy >= p_vv[id] + p_vf[id] && e.sy < p_vv[id] + p_vf[id] + p_vs[id]) ? vp : !vp;
        e.ls    = rn && ce && (e.sxa == 0);
        e.fs    = rn && ce && (a == 0);
        // Frames counted = advances that departed from ahead (0,0).
        k0      = (t - p_la[id]) % t;
        e.fc    = (n > k0) ? int'(((n - 1 - k0) / t + 1) % 65536) : 0;
        return e;
    endfunction

    function automatic exp_t actual(input int id);
        exp_t r;
        r = '0;
        case (id)
            0: begin r.sx = int'(a_sx); r.sy = int'(a_sy); r.sxa = int'(a_sxa); r.sya = int'(a_sya);
                     r.de = a_de; r.hs = a_hs; r.vs = a_vs; r.dea = a_dea; r.ls = a_ls; r.fs = a_fs; end
            1: begin r.sx = int'(b_sx); r.sy = int'(b_sy); r.sxa = int'(b_sxa); r.sya = int'(b_sya);
                     r.de = b_de; r.hs = b_hs; r.vs = b_vs; r.dea = b_dea; r.ls = b_ls; r.fs = b_fs; end
            2: begin r.sx = int'(c_sx); r.sy = int'(c_sy); r.sxa = int'(c_sxa); r.sya = int'(c_sya);
                     r.de = c_de; r.hs = c_hs; r.vs = c_vs; r.dea = c_dea; r.ls = c_ls; r.fs = c_fs; end
            default: begin r.sx = int'(d_sx); r.sy = int'(d_sy); r.sxa = int'(d_sxa); r.sya = int'(d_sya);
                     r.de = d_de; r.hs = d_hs; r.vs = d_vs; r.dea = d_dea; r.ls = d_ls; r.fs = d_fs; end
        endcase
`ifdef FRAME_COUNTER_EN
        case (id)
            0:       r.fc = int'(a_fc);
            1:       r.fc = int'(b_fc);
            2:       r.fc = int'(c_fc);
            default: r.fc = int'(d_fc);
        endcase
`endif
        return r;
    endfunction

    // Monitor: consumes expectations stamped for the current cycle at the falling edge.
    initial begin
        exp_t e, r;
        bit   bad;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc_now) begin
                e = q.pop_front();
                vectors++;
                if (e.cyc != cyc_now) begin
                    errors++;
                    $display("FAIL %s inst%0d: vector for cycle %0d checked at cycle %0d",
                             kind_name(e.kind), e.id, e.cyc, cyc_now);
                end else begin
                    r   = actual(e.id);
                    bad = (r.sx != e.sx) || (r.sy != e.sy) || (r.sxa != e.sxa) || (r.sya != e.sya) ||
                          (r.de != e.de) || (r.hs != e.hs) || (r.vs != e.vs) || (r.dea != e.dea) ||
                          (r.ls != e.ls) || (r.fs != e.fs);
`ifdef FRAME_COUNTER_EN
                    bad = bad || (r.fc != e.fc);
`endif
                    if (bad) begin
                        errors++;
                        $display("FAIL %s inst%0d cyc%0d got sx=%0d sy=%0d sxa=%0d sya=%0d de=%0b hs=%0b vs=%0b dea=%0b ls=%0b fs=%0b fc=%0d want sx=%0d sy=%0d sxa=%0d sya=%0d de=%0b hs=%0b vs=%0b dea=%0b ls=%0b fs=%0b fc=%0d",
                                 kind_name(e.kind), e.id, cyc_now,
                                 r.sx, r.sy, r.sxa, r.sya, r.de, r.hs, r.vs, r.dea, r.ls, r.fs, r.fc,
                                 e.sx, e.sy, e.sxa, e.sya, e.de, e.hs, e.vs, e.dea, e.ls, e.fs, e.fc);
                    end
                end
            end
        end
    end

    // One clock of stimulus: inputs change 1 time unit after the rising edge,
    // then the model's view of every instance is queued for this cycle.
    task automatic tick(input bit rn_new, input bit ce_new);
        @(posedge clk);
        if (rst_n && pix_ce) n_adv++;
        #1;
        rst_n  = rn_new;
        pix_ce = ce_new;
        if (!rn_new) n_adv = 0;
        for (int id = 0; id < N; id++) q.push_back(model(id, n_adv, rn_new, ce_new));
    endtask

    // Hand-computed vector for the current cycle (frame count from the model).
    task automatic push_lit(input int kind, input int id, input int sx, input int sy,
                            input bit de, input bit hs, input bit vs,
                            input int sxa, input int sya, input bit dea, input bit ls, input bit fs);
        exp_t e;
        e      = model(id, n_adv, rst_n, pix_ce);
        e.kind = kind;
        e.sx   = sx;  e.sy  = sy;  e.de  = de;  e.hs = hs; e.vs = vs;
        e.sxa  = sxa; e.sya = sya; e.dea = dea; e.ls = ls; e.fs = fs;
        q.push_back(e);
    endtask

    initial begin
        // Reset held: reset values on every instance, strobes suppressed.
        tick(1'b0, 1'b1);
        push_lit(1, 0, 0, 0, 1, 1, 1, 3,   0, 1, 0, 0);
        push_lit(2, 1, 0, 0, 1, 1, 1, 799, 0, 0, 0, 0);
        push_lit(3, 2, 0, 0, 1, 0, 0, 5,   0, 1, 0, 0);
        push_lit(4, 3, 0, 0, 1, 1, 1, 0,   0, 1, 0, 0);
        tick(1'b0, 1'b1);

        // Free run at full rate: iteration i sits at pixel index i.
        for (int i = 0; i < 900; i++) begin
            tick(1'b1, 1'b1);
            case (i)
                1:   push_lit(7, 1, 1,   0, 1, 1, 1, 0,   1, 1, 1, 0);
                80:  push_lit(8, 2, 0,   5, 0, 0, 1, 5,   5, 0, 0, 0);
                123: push_lit(9, 2, 11,  7, 0, 1, 0, 0,   0, 1, 1, 1);
                655: push_lit(5, 0, 655, 0, 0, 1, 1, 658, 0, 0, 0, 0);
                656: push_lit(5, 0, 656, 0, 0, 0, 1, 659, 0, 0, 0, 0);
                751: push_lit(5, 0, 751, 0, 0, 0, 1, 754, 0, 0, 0, 0);
                752: push_lit(5, 0, 752, 0, 0, 1, 1, 755, 0, 0, 0, 0);
                797: push_lit(6, 0, 797, 0, 0, 1, 1, 0,   1, 1, 1, 0);
                default: ;
            endcase
        end

        // One-in-four enable: holds between advances, strobes only on enabled cycles.
        for (int i = 0; i < 600; i++) tick(1'b1, (i % 4) == 0);

        // Reset mid-frame: must take effect before the next clock edge.
        tick(1'b0, 1'b1);
        push_lit(10, 0, 0, 0, 1, 1, 1, 3, 0, 1, 0, 0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            tick(1'b1, 1'b1);
            if (i == 123) push_lit(9, 2, 11, 7, 0, 1, 0, 0, 0, 1, 1, 1);
        end

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            $display("FAIL unchecked_vectors: %0d left in queue, required 0", q.size());
            errors += q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
